// File: rtl/apb5_pkg.sv
// Shared definitions for the APB5 command master.
// Holds the transfer FSM encoding and the PPROT bit positions.
package apb5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

endpackage

// File: rtl/apb5_if_rev_e.sv
// APB5 (rev E) bus bundle with requester and completer views.
interface apb5_if_rev_e #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_REQ_WIDTH  = 32,
    parameter int USER_DATA_WIDTH = 32,
    parameter int USER_RESP_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]      paddr;
    logic [2:0]                 pprot;
    logic                       pnse;
    logic                       pselx;
    logic                       penable;
    logic                       pwrite;
    logic [DATA_WIDTH-1:0]      pwdata;
    logic [DATA_WIDTH/8-1:0]    pstrb;
    logic                       pready;
    logic [DATA_WIDTH-1:0]      prdata;
    logic                       pslverr;
    logic                       pwakeup;
    logic [USER_REQ_WIDTH-1:0]  pauser;
    logic [USER_DATA_WIDTH-1:0] pwuser;
    logic [USER_DATA_WIDTH-1:0] pruser;
    logic [USER_RESP_WIDTH-1:0] pbuser;

    modport master (
        output paddr, pprot, pnse, pselx, penable, pwrite, pwdata, pstrb,
               pwakeup, pauser, pwuser,
        input  pready, prdata, pslverr, pruser, pbuser
    );

    modport slave (
        input  paddr, pprot, pnse, pselx, penable, pwrite, pwdata, pstrb,
               pwakeup, pauser, pwuser,
        output pready, prdata, pslverr, pruser, pbuser
    );
endinterface

// File: rtl/apb5_rsp_reg.sv
// Response holding register: loads on a completed transfer, holds until consumed.
// A capture in the same cycle as a consume wins, so no response is ever dropped.
module apb5_rsp_reg #(
    parameter int DATA_WIDTH      = 32,
    parameter int USER_DATA_WIDTH = 32,
    parameter int USER_RESP_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       capture_i,
    input  logic                       ready_i,
    input  logic [DATA_WIDTH-1:0]      rdata_i,
    input  logic                       slverr_i,
    input  logic [USER_DATA_WIDTH-1:0] ruser_i,
    input  logic [USER_RESP_WIDTH-1:0] buser_i,
    output logic                       valid_o,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       slverr_o,
    output logic [USER_DATA_WIDTH-1:0] ruser_o,
    output logic [USER_RESP_WIDTH-1:0] buser_o
);
    logic                       valid_q, valid_d;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic                       slverr_q;
    logic [USER_DATA_WIDTH-1:0] ruser_q;
    logic [USER_RESP_WIDTH-1:0] buser_q;

    always_comb begin
        valid_d = valid_q;
        if (capture_i) begin
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            ruser_q  <= '0;
            buser_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (capture_i) begin
                rdata_q  <= rdata_i;
                slverr_q <= slverr_i;
                ruser_q  <= ruser_i;
                buser_q  <= buser_i;
            end
        end
    end

    assign valid_o  = valid_q;
    assign rdata_o  = rdata_q;
    assign slverr_o = slverr_q;
    assign ruser_o  = ruser_q;
    assign buser_o  = buser_q;
endmodule

// File: rtl/apb5_cmd_master.sv
// APB5 requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and parks the completion in a response register until it is consumed.
module apb5_cmd_master
    import apb5_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_REQ_WIDTH  = 32,
    parameter int USER_DATA_WIDTH = 32,
    parameter int USER_RESP_WIDTH = 32
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic                       cmd_write,
    input  logic [DATA_WIDTH-1:0]      cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]    cmd_strb,
    input  logic [2:0]                 cmd_prot,
    input  logic                       cmd_nse,
    input  logic [USER_REQ_WIDTH-1:0]  cmd_auser,
    input  logic [USER_DATA_WIDTH-1:0] cmd_wuser,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_slverr,
    output logic [USER_DATA_WIDTH-1:0] rsp_ruser,
    output logic [USER_RESP_WIDTH-1:0] rsp_buser,
    apb5_if_rev_e.master               m
);
    apb_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]      addr_q;
    logic                       write_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [DATA_WIDTH/8-1:0]    strb_q;
    logic [2:0]                 prot_q;
    logic                       nse_q;
    logic [USER_REQ_WIDTH-1:0]  auser_q;
    logic [USER_DATA_WIDTH-1:0] wuser_q;

    logic accept;
    logic capture;
    logic psel;
    logic pen;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        psel      = 1'b0;
        pen       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = !preset && (!rsp_valid || rsp_ready);
                if (cmd_valid && cmd_ready) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                psel    = !preset;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel = !preset;
                pen  = !preset;
                if (m.pready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept  = cmd_valid && cmd_ready;
    assign capture = pen && m.pready;

    // Write-only fields are zeroed at load so reads never leak stale data onto the bus.
    always_ff @(posedge pclk) begin
        if (preset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            nse_q   <= 1'b0;
            auser_q <= '0;
            wuser_q <= '0;
        end else if (accept) begin
            addr_q               <= cmd_addr;
            write_q              <= cmd_write;
            wdata_q              <= cmd_write ? cmd_wdata : '0;
            strb_q               <= cmd_write ? cmd_strb : '0;
            prot_q[PPROT_PRIV]   <= cmd_prot[PPROT_PRIV];
            prot_q[PPROT_NONSEC] <= cmd_prot[PPROT_NONSEC];
            prot_q[PPROT_INSTR]  <= cmd_prot[PPROT_INSTR];
            nse_q                <= cmd_nse;
            auser_q              <= cmd_auser;
            wuser_q              <= cmd_write ? cmd_wuser : '0;
        end
    end

    assign m.pselx   = psel;
    assign m.penable = pen;
    assign m.pwakeup = psel;
    assign m.paddr   = addr_q;
    assign m.pwrite  = write_q;
    assign m.pwdata  = wdata_q;
    assign m.pstrb   = strb_q;
    assign m.pprot   = prot_q;
    assign m.pnse    = nse_q;
    assign m.pauser  = auser_q;
    assign m.pwuser  = wuser_q;

    apb5_rsp_reg #(
        .DATA_WIDTH      (DATA_WIDTH),
        .USER_DATA_WIDTH (USER_DATA_WIDTH),
        .USER_RESP_WIDTH (USER_RESP_WIDTH)
    ) u_rsp (
        .clk_i     (pclk),
        .rst_i     (preset),
        .capture_i (capture),
        .ready_i   (rsp_ready),
        .rdata_i   (write_q ? '0 : m.prdata),
        .slverr_i  (m.pslverr),
        .ruser_i   (write_q ? '0 : m.pruser),
        .buser_i   (m.pbuser),
        .valid_o   (rsp_valid),
        .rdata_o   (rsp_rdata),
        .slverr_o  (rsp_slverr),
        .ruser_o   (rsp_ruser),
        .buser_o   (rsp_buser)
    );
endmodule

// File: doc/apb5_cmd_master.md
APB5_CMD_MASTER -- requirements
Module: apb5_cmd_master

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all logic samples on the rising edge of pclk.
REQ-002 Parameters SHALL be: ADDR_WIDTH, 32, APB address width; DATA_WIDTH, 32, data width (multiple of 8).
REQ-003 Parameters SHALL also be: USER_REQ_WIDTH, 32, pauser width; USER_DATA_WIDTH, 32, pwuser/pruser width; USER_RESP_WIDTH, 32, pbuser width.
REQ-004 pclk  in  1  clock.
REQ-005 preset  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_addr  in  ADDR_WIDTH  transfer address.
REQ-009 cmd_write  in  1  1=write, 0=read.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 cmd_strb  in  DATA_WIDTH/8  write byte strobes.
REQ-012 cmd_prot  in  3  pprot value (bit0 privileged, bit1 non-secure, bit2 instruction).
REQ-013 cmd_nse  in  1  pnse value.
REQ-014 cmd_auser  in  USER_REQ_WIDTH  request user.
REQ-015 cmd_wuser  in  USER_DATA_WIDTH  write-data user.
REQ-016 rsp_valid  out  1  response held.
REQ-017 rsp_ready  in  1  response consumed.
REQ-018 rsp_rdata / rsp_slverr / rsp_ruser / rsp_buser  out  DATA_WIDTH / 1 / USER_DATA_WIDTH / USER_RESP_WIDTH  captured prdata, pslverr, pruser, pbuser.
REQ-019 m  apb5_if_rev_e.master modport  --  APB5 rev E requester port, all parameters passed through.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-021 cmd_ready SHALL be high only in IDLE when rsp_valid is low or rsp_ready is high that cycle.
REQ-022 On acceptance, all cmd_* fields SHALL be registered and the FSM SHALL go IDLE->SETUP; APB outputs SHALL be driven only from the registers.
REQ-023 SETUP: pselx=1, penable=0; next cycle unconditionally ACCESS.
REQ-024 ACCESS: pselx=1, penable=1; hold all request signals stable until pready=1, with no timeout.
REQ-025 On ACCESS with pready=1: capture prdata, pslverr, pruser, pbuser into the response register, set rsp_valid, and return to IDLE.
REQ-026 For reads, captured rdata/ruser SHALL be the sampled values; for writes, rsp_rdata and rsp_ruser SHALL be 0.
REQ-027 pstrb SHALL be all zeros for reads regardless of cmd_strb; pwdata and pwuser SHALL be 0 for reads.
REQ-028 rsp_valid SHALL stay high with stable payload until rsp_ready; it clears on rsp_ready unless a new capture occurs in the same cycle, in which case it stays high with the new payload.
REQ-029 pwakeup SHALL be high from the cycle after acceptance until the ACCESS cycle where pready=1, inclusive; otherwise 0.
REQ-030 Minimum issue interval SHALL be 3 cycles (IDLE accept, SETUP, ACCESS); latency from accept to rsp_valid = 3 + wait states.
REQ-031 In IDLE: pselx=0, penable=0, and address/control SHALL hold their last values.

Reset
REQ-032 While preset is high, the FSM SHALL be IDLE; pselx, penable, pwakeup, rsp_valid, and cmd_ready SHALL be 0; and all registered payload/APB outputs SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer with no response; cmd_ready SHALL be allowed high the first cycle after reset deasserts.

Structure
REQ-034 The FSM state enum and PPROT bit-index constants SHALL be in a shared package, apb5_pkg.
REQ-035 The response holding register SHALL be a natural sub-module, apb5_rsp_reg; everything else is inline.

Verification
REQ-036 Write 0x10, data 0xDEADBEEF, strb 0xF, pready tied 1 -> SETUP then ACCESS, pwrite=1, pstrb=0xF, rsp_valid 3 cycles after accept, rsp_slverr=0, rsp_rdata=0.
REQ-037 Read 0x20 with cmd_strb 0xF, slave 2 wait states, prdata 0x12345678 -> pstrb=0, paddr stable for 4 cycles, rsp_rdata=0x12345678 at cycle 5.
REQ-038 Read with pslverr=1 on the completion cycle -> rsp_slverr=1; other captured fields per REQ-026.
REQ-039 rsp_ready held 0 for 10 cycles with cmd_valid=1 -> cmd_ready stays 0 and the payload is stable; when rsp_ready=1, the next command is accepted the same cycle.
REQ-040 Reset pulsed during ACCESS with pready=0 -> pselx/penable/pwakeup are 0 the next cycle and no rsp_valid appears.
REQ-041 Back-to-back commands with rsp_ready=1 and pready=1 -> pselx pattern 0,1,1,0,1,1 and pprot/pnse match each command.
